m_proc_mc: RTL and testbench

M_PROC_MC -- requirements
Module: m_proc_mc

---
 rtl/m_proc_mc.sv | 158 +++++++++++++++
 tb/tb_m_proc_mc.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_proc_mc.sv
// rtl/m_proc_mc.sv - multicycle RV32I-subset core with program-load port
// One FSM state per cycle; retire/halt are decoded from state and the latched instruction.
module m_proc_mc #(
   parameter int          IMEM_WORDS = 64,
   parameter int          DMEM_WORDS = 64,
   parameter logic [31:0] RESET_PC   = 32'h0,
   parameter logic [4:0]  HALT_REG   = 5'd30,
   localparam int         AW         = $clog2(IMEM_WORDS),
   localparam int         DW         = $clog2(DMEM_WORDS)
) (
   input  logic          w_clk,
   input  logic          w_rst,
   input  logic          w_ld_we,
   input  logic [AW-1:0] w_ld_addr,
   input  logic [31:0]   w_ld_data,
   output logic [31:0]   w_pc,
   output logic [2:0]    w_state,
   output logic          w_retire,
   output logic          w_halt,
   output logic [31:0]   w_cycle
);

   typedef enum logic [2:0] {
      S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, cycle_q, ir_q, a_q, b_q, imm_q, alu_q, npc_q, mdr_q;
   logic [31:0] imm_d, alu_d, npc_d, wb_val, rs1_val, rs2_val;
   logic [31:0] imem_q [IMEM_WORDS];
   logic [31:0] dmem_q [DMEM_WORDS];
   logic [31:0] rf_q   [32];

   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic [4:0] rd, rs1, rs2;
   logic       is_add, is_sub, is_addi, is_lw, is_sw, is_beq, is_bne, is_lui, is_jal;
   logic       has_wb, taken;

   assign opc = ir_q[6:0];
   assign rd  = ir_q[11:7];
   assign f3  = ir_q[14:12];
   assign rs1 = ir_q[19:15];
   assign rs2 = ir_q[24:20];
   assign f7  = ir_q[31:25];

   assign is_add  = (opc == 7'h33) && (f3 == 3'd0) && (f7 == 7'h00);
   assign is_sub  = (opc == 7'h33) && (f3 == 3'd0) && (f7 == 7'h20);
   assign is_addi = (opc == 7'h13) && (f3 == 3'd0);
   assign is_lw   = (opc == 7'h03) && (f3 == 3'd2);
   assign is_sw   = (opc == 7'h23) && (f3 == 3'd2);
   assign is_beq  = (opc == 7'h63) && (f3 == 3'd0);
   assign is_bne  = (opc == 7'h63) && (f3 == 3'd1);
   assign is_lui  = (opc == 7'h37);
   assign is_jal  = (opc == 7'h6F);
   assign has_wb  = is_add | is_sub | is_addi | is_lw | is_lui | is_jal;

   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
   assign wb_val  = is_lw ? mdr_q : alu_q;

   always_comb begin
      imm_d = {{20{ir_q[31]}}, ir_q[31:20]};
      if (is_sw)
         imm_d = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      else if (is_beq || is_bne)
         imm_d = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      else if (is_jal)
         imm_d = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      else if (is_lui)
         imm_d = {ir_q[31:12], 12'h000};
   end

   // ALU result doubles as load/store address and as the JAL/LUI writeback value.
   always_comb begin
      alu_d = a_q + imm_q;
      if (is_add)      alu_d = a_q + b_q;
      else if (is_sub) alu_d = a_q - b_q;
      else if (is_lui) alu_d = imm_q;
      else if (is_jal) alu_d = pc_q + 32'd4;
      taken = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q)) || is_jal;
      npc_d = taken ? (pc_q + imm_q) : (pc_q + 32'd4);
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) state_q <= S_IF;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF:    state_d = S_ID;
         S_ID:    state_d = S_EX;
         S_EX:    state_d = (is_lw || is_sw) ? S_MEM : (has_wb ? S_WB : S_IF);
         S_MEM:   state_d = is_lw ? S_WB : S_IF;
         S_WB:    state_d = ((rd == HALT_REG) && (rd != 5'd0)) ? S_HALT : S_IF;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IF;
      endcase
   end

   always_comb begin
      w_retire = ((state_q == S_EX) && !(is_sw || has_wb)) ||
                 ((state_q == S_MEM) && is_sw) ||
                 (state_q == S_WB);
      w_halt   = (state_q == S_HALT);
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         pc_q    <= RESET_PC;
         cycle_q <= 32'd0;
      end else begin
         if (state_q != S_HALT && cycle_q != 32'hFFFF_FFFF)
            cycle_q <= cycle_q + 32'd1;
         if (w_retire)
            pc_q <= (state_q == S_EX) ? npc_d : npc_q;
         case (state_q)
            S_IF:  ir_q <= imem_q[pc_q[AW+1:2]];
            S_ID: begin
               a_q   <= rs1_val;
               b_q   <= rs2_val;
               imm_q <= imm_d;
            end
            S_EX: begin
               alu_q <= alu_d;
               npc_q <= npc_d;
            end
            S_MEM: mdr_q <= dmem_q[alu_q[DW+1:2]];
            default: ;
         endcase
      end
   end

   always_ff @(posedge w_clk) begin
      if (w_rst && w_ld_we)
         imem_q[w_ld_addr] <= w_ld_data;
   end

   always_ff @(posedge w_clk) begin
      if (!w_rst && state_q == S_MEM && is_sw)
         dmem_q[alu_q[DW+1:2]] <= b_q;
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      end else if (state_q == S_WB && rd != 5'd0) begin
         rf_q[rd] <= wb_val;
      end
   end

   assign w_pc    = pc_q;
   assign w_state = state_q;
   assign w_cycle = cycle_q;

endmodule

// File: tb/tb_m_proc_mc.sv
// tb/tb_m_proc_mc.sv - self-checking bench for m_proc_mc against an instruction-level model
module tb_m_proc_mc;
   localparam int IMEM = 64;
   localparam int DMEM = 64;

   logic        w_clk = 1'b0;
   logic        w_rst = 1'b1;
   logic        w_ld_we = 1'b0;
   logic [5:0]  w_ld_addr = '0;
   logic [31:0] w_ld_data = '0;
   logic [31:0] w_pc, w_cycle;
   logic [2:0]  w_state;
   logic        w_retire, w_halt;

   m_proc_mc dut (
      .w_clk(w_clk), .w_rst(w_rst), .w_ld_we(w_ld_we), .w_ld_addr(w_ld_addr),
      .w_ld_data(w_ld_data), .w_pc(w_pc), .w_state(w_state), .w_retire(w_retire),
      .w_halt(w_halt), .w_cycle(w_cycle)
   );

   always #5 w_clk = ~w_clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_imem [IMEM];
   logic [31:0] m_dmem [DMEM];
   logic [31:0] m_rf   [32];
   logic [31:0] m_pc, m_cycle;
   bit          m_halt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] f_r(logic [6:0] f7, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
      return {f7, rs2, rs1, 3'd0, rd, 7'h33};
   endfunction
   function automatic logic [31:0] f_i(logic [6:0] op, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] f_addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
      return f_i(7'h13, 3'd0, rd, rs1, imm);
   endfunction
   function automatic logic [31:0] f_lw(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
      return f_i(7'h03, 3'd2, rd, rs1, imm);
   endfunction
   function automatic logic [31:0] f_sw(logic [4:0] rs2, logic [4:0] rs1, logic [11:0] imm);
      return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] f_b(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2, logic [12:0] off);
      return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
   endfunction
   function automatic logic [31:0] f_lui(logic [4:0] rd, logic [19:0] u);
      return {u, rd, 7'h37};
   endfunction
   function automatic logic [31:0] f_jal(logic [4:0] rd, logic [20:0] off);
      return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
   endfunction

   function automatic logic [31:0] rand_ins();
      logic [4:0] rd  = 5'($urandom_range(0, 7));
      logic [4:0] rs1 = 5'($urandom_range(0, 7));
      logic [4:0] rs2 = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
         0: return f_r(7'h00, rd, rs1, rs2);
         1: return f_r(7'h20, rd, rs1, rs2);
         2: return f_addi(rd, rs1, 12'($urandom));
         3: return f_lw(rd, rs1, 12'($urandom));
         4: return f_sw(rs2, rs1, 12'($urandom));
         5: return f_b(3'd0, rs1, rs2, 13'(4 * $urandom_range(1, 4)));
         6: return f_b(3'd1, rs1, rs2, 13'(4 * $urandom_range(1, 4)));
         7: return f_lui(rd, 20'($urandom));
         8: return f_jal(rd, 21'(4 * $urandom_range(1, 4)));
         default: return {25'($urandom), 7'h0B};
      endcase
   endfunction

   task automatic model_reset();
      m_pc = 32'd0;
      m_cycle = 32'd0;
      m_halt = 1'b0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
   endtask

   // Executes one whole instruction architecturally and reports its cycle count.
   task automatic model_step(output int len, output bit hlt);
      logic [31:0] ins, a, b, val, npc, addr;
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      logic [4:0]  rd;
      int          si, ss, sb, sj;
      bit          wr;
      ins = m_imem[(m_pc >> 2) % IMEM];
      op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
      a = m_rf[ins[19:15]];
      b = m_rf[ins[24:20]];
      si = $signed(ins[31:20]);
      ss = $signed({ins[31:25], ins[11:7]});
      sb = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      sj = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      len = 3; wr = 1'b0; val = 32'd0; npc = m_pc + 32'd4;
      if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin
         val = a + b; wr = 1'b1; len = 4;
      end else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin
         val = a - b; wr = 1'b1; len = 4;
      end else if (op == 7'h13 && f3 == 3'd0) begin
         val = a + si; wr = 1'b1; len = 4;
      end else if (op == 7'h03 && f3 == 3'd2) begin
         addr = a + si;
         val = m_dmem[(addr >> 2) % DMEM]; wr = 1'b1; len = 5;
      end else if (op == 7'h23 && f3 == 3'd2) begin
         addr = a + ss;
         m_dmem[(addr >> 2) % DMEM] = b; len = 4;
      end else if (op == 7'h63 && f3 == 3'd0) begin
         if (a == b) npc = m_pc + sb;
      end else if (op == 7'h63 && f3 == 3'd1) begin
         if (a != b) npc = m_pc + sb;
      end else if (op == 7'h37) begin
         val = {ins[31:12], 12'h000}; wr = 1'b1; len = 4;
      end else if (op == 7'h6F) begin
         val = m_pc + 32'd4; npc = m_pc + sj; wr = 1'b1; len = 4;
      end
      if (wr && rd != 5'd0) m_rf[rd] = val;
      hlt = wr && (rd == 5'd30);
      m_pc = npc;
      m_cycle = m_cycle + 32'(len);
   endtask

   // Caller is positioned just after the edge that starts an instruction's IF cycle.
   task automatic run_instrs(input int n, input string tag);
      int len;
      bit h;
      for (int k = 0; k < n && !m_halt; k++) begin
         model_step(len, h);
         for (int c = 1; c <= len; c++) begin
            @(negedge w_clk);
            chk({tag, " retire"}, 32'(w_retire), 32'(c == len));
         end
         @(posedge w_clk); #1;
         chk({tag, " pc"}, w_pc, m_pc);
         chk({tag, " cycle"}, w_cycle, m_cycle);
         chk({tag, " halt"}, 32'(w_halt), 32'(h));
         m_halt = h;
      end
   endtask

   task automatic do_reset(input string tag);
      w_rst = 1'b1;
      repeat (2) @(posedge w_clk);
      #1;
      chk({tag, " pc"}, w_pc, 32'd0);
      chk({tag, " state"}, 32'(w_state), 32'd0);
      chk({tag, " halt"}, 32'(w_halt), 32'd0);
      chk({tag, " cycle"}, w_cycle, 32'd0);
      chk({tag, " retire"}, 32'(w_retire), 32'd0);
      w_rst = 1'b0;
      model_reset();
   endtask

   task automatic load_prog(input string tag);
      w_rst = 1'b1;
      for (int i = 0; i < IMEM; i++) begin
         w_ld_we = 1'b1;
         w_ld_addr = 6'(i);
         w_ld_data = m_imem[i];
         @(posedge w_clk); #1;
      end
      w_ld_we = 1'b0;
      do_reset(tag);
   endtask

   task automatic fill_halt();
      for (int i = 0; i < IMEM; i++) m_imem[i] = f_addi(5'd30, 5'd0, 12'd0);
   endtask

   task automatic compare_state(input string tag);
      for (int i = 1; i < 32; i++) chk($sformatf("%s x%0d", tag, i), dut.rf_q[i], m_rf[i]);
      for (int j = 0; j < DMEM; j++) chk($sformatf("%s dmem%0d", tag, j), dut.dmem_q[j], m_dmem[j]);
   endtask

   initial begin
      for (int j = 0; j < DMEM; j++) m_dmem[j] = 32'd0;
      model_reset();

      fill_halt();
      m_imem[0] = f_addi(5'd1, 5'd0, 12'd5);
      m_imem[1] = f_addi(5'd2, 5'd1, 12'd7);
      m_imem[2] = f_r(7'h00, 5'd30, 5'd1, 5'd2);
      load_prog("reset");
      run_instrs(10, "add3");
      chk("add3 x30", dut.rf_q[30], 32'd17);
      chk("add3 cycle", w_cycle, 32'd12);
      repeat (3) @(posedge w_clk);
      #1;
      chk("halt hold cycle", w_cycle, 32'd12);
      chk("halt hold state", 32'(w_state), 32'd5);
      chk("halt hold pc", w_pc, 32'd12);

      do_reset("rst2");
      run_instrs(1, "pre");
      @(posedge w_clk);
      @(posedge w_clk);
      #1;
      chk("mid state EX", 32'(w_state), 32'd2);
      w_rst = 1'b1;
      @(posedge w_clk); #1;
      w_rst = 1'b0;
      model_reset();
      chk("midrst state", 32'(w_state), 32'd0);
      chk("midrst pc", w_pc, 32'd0);
      chk("midrst x1", dut.rf_q[1], 32'd0);
      chk("midrst x2", dut.rf_q[2], 32'd0);
      run_instrs(10, "rerun");
      chk("rerun x30", dut.rf_q[30], 32'd17);
      chk("rerun cycle", w_cycle, 32'd12);

      w_ld_we = 1'b1;
      w_ld_addr = 6'd0;
      w_ld_data = 32'hFFFF_FFFF;
      repeat (2) @(posedge w_clk);
      #1;
      w_ld_we = 1'b0;
      chk("ldign cycle", w_cycle, 32'd12);
      do_reset("rst3");
      run_instrs(10, "ldign");
      chk("ldign x30", dut.rf_q[30], 32'd17);

      fill_halt();
      m_imem[0] = f_addi(5'd1, 5'd0, 12'h055);
      m_imem[1] = f_sw(5'd1, 5'd0, 12'd8);
      m_imem[2] = f_lw(5'd3, 5'd0, 12'd8);
      m_imem[3] = f_addi(5'd30, 5'd3, 12'd0);
      load_prog("rst4");
      run_instrs(10, "swlw");
      chk("swlw x30", dut.rf_q[30], 32'h55);
      chk("swlw cycle", w_cycle, 32'd17);

      fill_halt();
      m_imem[0] = f_b(3'd0, 5'd0, 5'd0, 13'd8);
      m_imem[1] = f_addi(5'd5, 5'd0, 12'd1);
      load_prog("rst5");
      run_instrs(1, "beq");
      chk("beq pc", w_pc, 32'd8);
      chk("beq cycle", w_cycle, 32'd3);
      run_instrs(10, "beq tail");

      fill_halt();
      m_imem[0] = f_b(3'd1, 5'd0, 5'd0, 13'd8);
      load_prog("rst6");
      run_instrs(1, "bne");
      chk("bne pc", w_pc, 32'd4);
      run_instrs(10, "bne tail");

      fill_halt();
      m_imem[0] = 32'hFFFF_FFFF;
      load_prog("rst7");
      run_instrs(1, "nop");
      chk("nop pc", w_pc, 32'd4);
      chk("nop cycle", w_cycle, 32'd3);
      chk("nop x31", dut.rf_q[31], 32'd0);
      run_instrs(10, "nop tail");

      fill_halt();
      m_imem[0] = f_addi(5'd2, 5'd0, 12'd256);
      m_imem[1] = f_sw(5'd0, 5'd1, 12'd0);
      m_imem[2] = f_addi(5'd1, 5'd1, 12'd4);
      m_imem[3] = f_b(3'd1, 5'd1, 5'd2, 13'h1FF8);
      for (int j = 0; j < DMEM; j++) m_dmem[j] = 32'd0;
      load_prog("rst8");
      run_instrs(400, "clr");
      chk("clr halt", 32'(w_halt), 32'd1);
      compare_state("clr");

      for (int p = 0; p < 5; p++) begin
         for (int i = 0; i < IMEM - 1; i++) m_imem[i] = rand_ins();
         m_imem[IMEM-1] = f_addi(5'd30, 5'd0, 12'd1);
         load_prog("rrst");
         run_instrs(150, "rnd");
         compare_state("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
